vga_dither332: RTL and testbench
================================

# vga_dither332

Output colour-reduction stage between the Next186 SoC `system` core and the LX9 board VGA pins. It consumes the core's 6:6:6 RGB and both sync signals, and drives the board's 3:3:2 resistor DAC. Instead of bit truncation it applies 4×4 ordered (Bayer) dithering, with optional per-frame pattern rotation. Pixel position is derived from the sync edges, so no pixel strobe is required from the core.

## Interface
Parameters:
- `PIX_DIV`, 2: `CLK_50M` cycles per pixel (1..4).
- `HS_POL`, 0: active level of HSYNC.
- `VS_POL`, 0: active level of VSYNC.
- `TEMPORAL`, 1: 1 = rotate the dither pattern each frame; 0 = static pattern.

Ports:
- `CLK_50M`, in, 1: sole clock; all state updates on the rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `EN`, in, 1: 1 = dither; 0 = plain truncation.
- `R6`, in, 6: red from core.
- `G6`, in, 6: green from core.
- `B6`, in, 6: blue from core.
- `HSYNC_IN`, in, 1: horizontal sync from core.
- `VSYNC_IN`, in, 1: vertical sync from core.
- `VGA_R`, out, 3: red to DAC.
- `VGA_G`, out, 3: green to DAC.
- `VGA_B`, out, 2: blue to DAC.
- `VGA_HSYNC`, out, 1: delayed horizontal sync.
- `VGA_VSYNC`, out, 1: delayed vertical sync.

## Operation
**Sync edge detection**
- `hs_q` and `vs_q` hold the previous-cycle sync inputs.
- HS trailing edge: `HSYNC_IN` inactive and `hs_q` active.
- VS leading edge: `VSYNC_IN` active and `vs_q` inactive.

**Position counters**
- `div` counts 0..PIX_DIV-1. `x` is 2 bits, `y` is 2 bits, `frame` is 2 bits; all wrap modulo 4.
- On an HS trailing edge: `div`←0, `x`←0, and `y`←`y`+1 unless `VSYNC_IN` is active.
- Otherwise, when `div`==PIX_DIV-1: `div`←0 and `x`←`x`+1. Else `div`←`div`+1.
- While `VSYNC_IN` is active, `y` is held at 3, so the first line after vsync is `y`=0.
- On a VS leading edge: `frame`←`frame`+1.
- Simultaneous HS trailing edge and VS leading edge: both rules apply. `y` goes to 3 and `frame` increments.

**Bayer index**
- The pixel sampled in cycle k uses the counter values in effect during cycle k, before that edge's update.
- With TEMPORAL=1: `xi` = `x` ^ {`frame[0]`,`frame[1]`} and `yi` = `y` ^ {`frame[1]`,1'b0}.
- With TEMPORAL=0: `xi`=`x` and `yi`=`y`.
- `b` = M[`yi`][`xi`], where M rows are {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.

**Arithmetic**
- All sums are 7 bits wide, so there is no overflow.
- R/G with EN=1: out = min(7, (c + (b>>1)) >> 3).
- B with EN=1: out = min(3, (c + b) >> 4).
- EN=0: R/G out = c[5:3]; B out = c[5:4].
- Blanking: if the delayed HSYNC or VSYNC is active at the output stage, the RGB outputs are forced to 0.

**Pipeline**
- Stage 1 registers the RGB inputs, syncs, `b` and EN.
- Stage 2 computes the sum, saturates, blanks, and registers the outputs.
- Syncs pass through both stages unmodified.

**Reset**
- `VGA_R`, `VGA_G` and `VGA_B` = 0.
- `VGA_HSYNC` = ~HS_POL and `VGA_VSYNC` = ~VS_POL.
- `div`, `x`, `frame` = 0; `y` = 3.
- `hs_q` and `vs_q` are set to the inactive level, and both pipeline stages are cleared to the same values.
- A reset asserted mid-line takes effect on the next edge; the in-flight pixels are discarded.

## Timing
- Latency: input values in cycle k appear on the outputs after edge k+1, i.e. exactly 2 cycles. The latency is identical for RGB and sync, so relative alignment is preserved.
- Throughput: one new sample per clock, with no stall and no handshake.
- EN changes take effect on the pixel sampled in the same cycle and reach the outputs 2 cycles later.
- In the first 2 cycles after `RST` deasserts, the outputs show the reset values.

## Test plan
- **Reset:** hold `RST` 3 cycles with HS_POL=VS_POL=0 → RGB=0, `VGA_HSYNC`=`VGA_VSYNC`=1, and they stay so for 2 cycles after release.
- **Truncation:** EN=0, R6=20, G6=45, B6=63, syncs inactive → 2 cycles later `VGA_R`=2, `VGA_G`=5, `VGA_B`=3.
- **Static dither:** TEMPORAL=0, PIX_DIV=2, EN=1. Drive a vsync pulse, then one hsync pulse, then R6=20 and B6=20 constant. Expected outputs:
  - x=0: R=2 (b=0), B=1.
  - x=1 (clocks 2-3 after the trailing edge): R=3 (b=8), B=1.
  - x=3 on line y=3, R6=6: R=1 (b=5).
- **Saturation:** EN=1, R6=G6=B6=63 at b=15 → R=7, G=7, B=3, with no wrap to 0.
- **Temporal rotation:** TEMPORAL=1, same pixel (x=0, y=0) across 4 frames with R6=20:
  - frame 0→1 moves xi to 2 (b=2), giving R=2.
  - frame 2 gives yi=2, xi=1 (b=11), giving R=3.
  - check all 4 frames against the formula.
- **Sync and blanking:** assert `HSYNC_IN` for 10 cycles with R6=63 → `VGA_HSYNC` low for exactly 10 cycles, delayed 2 cycles, with RGB=0 during that window. The pixel after the trailing edge uses x=0.

Source files
------------

// File: rtl/vga_dither332.sv
// vga_dither332: reduces 6:6:6 RGB to the 3:3:2 DAC with 4x4 ordered (Bayer)
// dithering. Pixel position comes from the sync edges, so no pixel strobe is needed.
// Two register stages; syncs travel with the pixel so alignment is preserved.
module vga_dither332 #(
  parameter int PIX_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit TEMPORAL = 1'b1
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       EN,
  input  logic [5:0] R6,
  input  logic [5:0] G6,
  input  logic [5:0] B6,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [1:0] VGA_B,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC
);

  localparam int DATA_W = 6;
  localparam int COEF_W = 4;
  localparam int SUM_W  = DATA_W + 1;
  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);

  // 4x4 Bayer threshold matrix, row = yi, column = xi.
  function automatic logic [COEF_W-1:0] bayer(input logic [1:0] yi, input logic [1:0] xi);
    case ({yi, xi})
      4'h0: bayer = 4'd0;   4'h1: bayer = 4'd8;   4'h2: bayer = 4'd2;   4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;  4'h5: bayer = 4'd4;   4'h6: bayer = 4'd14;  4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;   4'h9: bayer = 4'd11;  4'hA: bayer = 4'd1;   4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;  4'hD: bayer = 4'd7;   4'hE: bayer = 4'd13;  default: bayer = 4'd5;
    endcase
  endfunction

  // 6-bit channel to 3 bits: add half the threshold, drop 3 LSBs, clamp at 7.
  function automatic logic [2:0] dith_rg(input logic [DATA_W-1:0] c, input logic [COEF_W-1:0] t,
                                         input logic en);
    logic [SUM_W-1:0] s;
    logic [3:0]       q;
    s = {1'b0, c} + SUM_W'(t >> 1);
    q = 4'(s >> 3);
    if (!en)      dith_rg = c[5:3];
    else if (q[3]) dith_rg = 3'd7;
    else          dith_rg = q[2:0];
  endfunction

  // 6-bit channel to 2 bits: add the full threshold, drop 4 LSBs, clamp at 3.
  function automatic logic [1:0] dith_b(input logic [DATA_W-1:0] c, input logic [COEF_W-1:0] t,
                                        input logic en);
    logic [SUM_W-1:0] s;
    logic [2:0]       q;
    s = {1'b0, c} + SUM_W'(t);
    q = 3'(s >> 4);
    if (!en)       dith_b = c[5:4];
    else if (q[2]) dith_b = 2'd3;
    else           dith_b = q[1:0];
  endfunction

  // Previous-cycle syncs; these also serve as the stage-1 sync registers.
  logic hs_q, vs_q;
  logic [1:0] div_q, div_d, x_q, x_d, y_q, y_d, frame_q, frame_d;
  logic hs_trail, vs_act, vs_lead;
  logic [1:0] xi, yi;
  logic [COEF_W-1:0] thr_now;

  logic [DATA_W-1:0] r_p1_q, g_p1_q, b_p1_q;
  logic [COEF_W-1:0] thr_p1_q;
  logic              en_p1_q;
  logic              blank_p1;

  logic [2:0] r_p2_q, g_p2_q;
  logic [1:0] b_p2_q;
  logic       hs_p2_q, vs_p2_q;

  // Next-state of the position counters from the sync edges and the pixel divider.
  always_comb begin
    vs_act   = (VSYNC_IN == VS_POL);
    hs_trail = (HSYNC_IN != HS_POL) && (hs_q == HS_POL);
    vs_lead  = vs_act && (vs_q != VS_POL);
    div_d    = div_q;
    x_d      = x_q;
    y_d      = y_q;
    frame_d  = frame_q;
    if (hs_trail) begin
      div_d = 2'd0;
      x_d   = 2'd0;
      y_d   = y_q + 2'd1;
    end else if (div_q == DIV_LAST) begin
      div_d = 2'd0;
      x_d   = x_q + 2'd1;
    end else begin
      div_d = div_q + 2'd1;
    end
    // Parking y at 3 during vsync makes the first visible line y=0.
    if (vs_act) y_d = 2'd3;
    if (vs_lead) frame_d = frame_q + 2'd1;
  end

  // Threshold for the pixel sampled this cycle, from the counters before this edge's update.
  always_comb begin
    xi = x_q;
    yi = y_q;
    if (TEMPORAL) begin
      xi = x_q ^ {frame_q[0], frame_q[1]};
      yi = y_q ^ {frame_q[1], 1'b0};
    end
    thr_now = bayer(yi, xi);
  end

  // Position counter registers.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      div_q   <= 2'd0;
      x_q     <= 2'd0;
      y_q     <= 2'd3;
      frame_q <= 2'd0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  // ---- Stage 1: capture pixel, syncs, threshold and enable ----
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      r_p1_q   <= '0;
      g_p1_q   <= '0;
      b_p1_q   <= '0;
      thr_p1_q <= '0;
      en_p1_q  <= 1'b0;
    end else begin
      hs_q     <= HSYNC_IN;
      vs_q     <= VSYNC_IN;
      r_p1_q   <= R6;
      g_p1_q   <= G6;
      b_p1_q   <= B6;
      thr_p1_q <= thr_now;
      en_p1_q  <= EN;
    end
  end

  assign blank_p1 = (hs_q == HS_POL) || (vs_q == VS_POL);

  // ---- Stage 2: dither, saturate, blank and drive the DAC ----
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_p2_q  <= '0;
      g_p2_q  <= '0;
      b_p2_q  <= '0;
      hs_p2_q <= ~HS_POL;
      vs_p2_q <= ~VS_POL;
    end else begin
      r_p2_q  <= blank_p1 ? 3'd0 : dith_rg(r_p1_q, thr_p1_q, en_p1_q);
      g_p2_q  <= blank_p1 ? 3'd0 : dith_rg(g_p1_q, thr_p1_q, en_p1_q);
      b_p2_q  <= blank_p1 ? 2'd0 : dith_b(b_p1_q, thr_p1_q, en_p1_q);
      hs_p2_q <= hs_q;
      vs_p2_q <= vs_q;
    end
  end

  assign VGA_R     = r_p2_q;
  assign VGA_G     = g_p2_q;
  assign VGA_B     = b_p2_q;
  assign VGA_HSYNC = hs_p2_q;
  assign VGA_VSYNC = vs_p2_q;

endmodule

// File: tb/tb_vga_dither332.sv
// Bench for vga_dither332: a static-pattern and a rotating-pattern instance share
// the same stimulus; a behavioural model predicts both every cycle.
module tb_vga_dither332;

  localparam int PIX  = 2;
  localparam int NMAX = 8192;

  typedef struct packed {
    logic [2:0] r0; logic [2:0] g0; logic [1:0] b0;
    logic [2:0] r1; logic [2:0] g1; logic [1:0] b1;
    logic hs; logic vs;
  } exp_t;

  logic clk, RST, EN, HSYNC_IN, VSYNC_IN;
  logic [5:0] R6, G6, B6;
  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;
  logic hs0, vs0, hs1, vs1;

  vga_dither332 #(.PIX_DIV(PIX), .HS_POL(1'b0), .VS_POL(1'b0), .TEMPORAL(1'b0)) dut0 (
    .CLK_50M(clk), .RST(RST), .EN(EN), .R6(R6), .G6(G6), .B6(B6),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HSYNC(hs0), .VGA_VSYNC(vs0));

  vga_dither332 #(.PIX_DIV(PIX), .HS_POL(1'b0), .VS_POL(1'b0), .TEMPORAL(1'b1)) dut1 (
    .CLK_50M(clk), .RST(RST), .EN(EN), .R6(R6), .G6(G6), .B6(B6),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HSYNC(hs1), .VGA_VSYNC(vs1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int BAY [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int TEMP_R [4] = '{2, 2, 3, 3};   // R6=20 at x=0,y=0 for frames 0..3

  exp_t pred [NMAX];
  bit   rst_h [NMAX];
  int   n = 0, kd = 0;
  bit   started = 1'b0;
  int   checks = 0, fails = 0;

  // Model state: cycles since last line start, lines since vsync, frames since reset.
  int m_since = 0, m_lines = 0, m_frames = 0;
  bit m_phs = 1'b0, m_pvs = 1'b0;
  int fcount = 0;

  exp_t want_c, got_c;

  function automatic exp_t reset_val();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic int q_rg(int c, int t, bit en);
    int v;
    if (!en) return c / 8;
    v = (c + t / 2) / 8;
    return (v > 7) ? 7 : v;
  endfunction

  function automatic int q_b(int c, int t, bit en);
    int v;
    if (!en) return c / 16;
    v = (c + t) / 16;
    return (v > 3) ? 3 : v;
  endfunction

  function automatic int bval(int x, int y, int f, bit temporal);
    int xi, yi;
    xi = x;
    yi = y;
    if (temporal) begin
      xi = x ^ ((f % 2) * 2 + f / 2);
      yi = y ^ ((f / 2) * 2);
    end
    return BAY[yi][xi];
  endfunction

  task automatic chk(string nm, int act, int want);
    checks++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // One clock of stimulus; hs_a/vs_a are "sync active" flags (pins are active-low).
  task automatic step(bit rst, bit en, int r, int g, int b, bit hs_a, bit vs_a);
    exp_t e;
    int x, y, f, ts, tt;
    bit trail, lead;
    @(negedge clk);
    if (n >= NMAX) begin
      $display("FAIL cycle_budget: used %0d, limit %0d", n, NMAX);
      $fatal(1, "cycle budget exhausted");
    end
    RST = rst; EN = en;
    R6 = 6'(r); G6 = 6'(g); B6 = 6'(b);
    HSYNC_IN = ~hs_a; VSYNC_IN = ~vs_a;
    e = '0;
    if (rst) begin
      e = reset_val();
      m_since = 0; m_lines = 0; m_frames = 0; m_phs = 1'b0; m_pvs = 1'b0;
    end else begin
      x  = (m_since / PIX) % 4;
      y  = (3 + m_lines) % 4;
      f  = m_frames % 4;
      ts = bval(x, y, f, 1'b0);
      tt = bval(x, y, f, 1'b1);
      e.hs = ~hs_a;
      e.vs = ~vs_a;
      if (!(hs_a || vs_a)) begin
        e.r0 = 3'(q_rg(r, ts, en)); e.g0 = 3'(q_rg(g, ts, en)); e.b0 = 2'(q_b(b, ts, en));
        e.r1 = 3'(q_rg(r, tt, en)); e.g1 = 3'(q_rg(g, tt, en)); e.b1 = 2'(q_b(b, tt, en));
      end
      trail = !hs_a && m_phs;
      lead  = vs_a && !m_pvs;
      m_since = trail ? 0 : m_since + 1;
      if (vs_a) m_lines = 0;
      else if (trail) m_lines++;
      if (lead) m_frames++;
      m_phs = hs_a;
      m_pvs = vs_a;
    end
    pred[n]  = e;
    rst_h[n] = rst;
    kd = n;
    n++;
    started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(int cnt, bit en, int r, int g, int b);
    repeat (cnt) step(1'b0, en, r, g, b, 1'b0, 1'b0);
  endtask

  task automatic hpulse(int len, int r, int g, int b);
    repeat (len) step(1'b0, 1'b1, r, g, b, 1'b1, 1'b0);
  endtask

  task automatic vpulse(int r, int g, int b);
    repeat (3) step(1'b0, 1'b1, r, g, b, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, r, g, b, 1'b0, 1'b0);
    fcount++;
  endtask

  // Per-cycle comparison of both instances against the model, two cycles behind the input.
  always begin
    @(posedge clk);
    #1;
    if (started) begin
      got_c = {r0, g0, b0, r1, g1, b1, hs0, vs0};
      if (rst_h[kd] || kd == 0) want_c = reset_val();
      else want_c = pred[kd-1];
      checks++;
      if (got_c !== want_c || hs1 !== want_c.hs || vs1 !== want_c.vs) begin
        fails++;
        $display("FAIL pipe cycle %0d: got %h (hs1=%b vs1=%b), expected %h", kd, got_c, hs1, vs1, want_c);
      end
    end
  end

  initial begin
    int lows, first, bad;
    int hl, vis, tot, sp;
    bit vs_cur, vs_nx, rr, ee;
    int rv, gv, bv;
    RST = 1'b1; EN = 1'b0; R6 = '0; G6 = '0; B6 = '0; HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;

    // Reset and release
    repeat (3) step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst_rgb", int'({r0, g0, b0}), 0);
    chk("rst_hsync", int'(hs0), 1);
    chk("rst_vsync", int'(vs0), 1);
    step(1'b0, 1'b0, 20, 45, 63, 1'b0, 1'b0);
    chk("rel_rgb", int'({r0, g0, b0}), 0);
    chk("rel_hsync", int'(hs0), 1);
    step(1'b0, 1'b0, 20, 45, 63, 1'b0, 1'b0);
    chk("trunc_r", int'(r0), 2);
    chk("trunc_g", int'(g0), 5);
    chk("trunc_b", int'(b0), 3);

    // Static dither: vsync, hsync, then constant R=B=20
    vpulse(20, 0, 20);
    hpulse(4, 20, 0, 20);
    pix(3, 1'b1, 20, 0, 20);
    chk("static_x0_r", int'(r0), 2);
    chk("static_x0_b", int'(b0), 1);
    pix(2, 1'b1, 20, 0, 20);
    chk("static_x1_r", int'(r0), 3);
    chk("static_x1_b", int'(b0), 1);
    pix(4, 1'b1, 20, 0, 20);
    for (int i = 0; i < 2; i++) begin
      hpulse(4, 20, 0, 20);
      pix(10, 1'b1, 20, 0, 20);
    end
    // Line y=3: saturation at x=0 (threshold 15), then R6=6 at x=3 (threshold 5)
    hpulse(4, 6, 0, 0);
    pix(2, 1'b1, 63, 63, 63);
    pix(1, 1'b1, 6, 0, 0);
    chk("sat_r", int'(r0), 7);
    chk("sat_g", int'(g0), 7);
    chk("sat_b", int'(b0), 3);
    pix(6, 1'b1, 6, 0, 0);
    chk("static_x3y3_r", int'(r0), 1);

    // Temporal rotation: pixel x=0,y=0 across four frames
    for (int i = 0; i < 4; i++) begin
      vpulse(20, 0, 20);
      hpulse(4, 20, 0, 20);
      pix(3, 1'b1, 20, 0, 20);
      chk($sformatf("temporal_f%0d_r", fcount % 4), int'(r1), TEMP_R[fcount % 4]);
      pix(4, 1'b1, 20, 0, 20);
    end

    // Sync delay and blanking: 10-cycle hsync with full-scale colour
    lows = 0; first = -1; bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 63, 63, 63, (i >= 1 && i <= 10), 1'b0);
      if (hs0 == 1'b0) begin
        lows++;
        if (first < 0) first = i;
        if ({r0, g0, b0, r1, g1, b1} != '0) bad++;
      end
    end
    chk("hs_low_len", lows, 10);
    chk("hs_delay", first, 2);
    chk("blank_rgb", bad, 0);

    // Randomized lines with random vsync placement, enable and occasional reset
    vs_cur = 1'b0;
    for (int ln = 0; ln < 140; ln++) begin
      hl  = $urandom_range(1, 5);
      vis = $urandom_range(6, 24);
      tot = hl + vis;
      sp  = $urandom_range(0, tot - 1);
      if (vs_cur) vs_nx = ($urandom_range(0, 1) == 0);
      else vs_nx = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < tot; c++) begin
        rr = ($urandom_range(0, 299) == 0);
        ee = ($urandom_range(0, 3) != 0);
        rv = ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 63);
        gv = ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 63);
        bv = ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 63);
        step(rr, ee, rv, gv, bv, (c < hl), (c < sp) ? vs_cur : vs_nx);
      end
      vs_cur = vs_nx;
    end

    pix(3, 1'b1, 0, 0, 0);
    #2;
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
